mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
- Memory controller sequencing the shared 8-bit ROM/RAM bus (wr_en, rd_en, rom_ram, 15-bit address, bidirectional data) between two requesters.
- Requesters: port 0 (instruction fetch, read-only) and port 1 (data load/store).
- Round-robin arbitration, fixed setup/access/ack timing, 16-bit address decode (bit 15 selects RAM), and guarding of writes to the ROM region.
- Sits between the CPU core and the ROM/RAM macros.

Parameters:
- WAIT_CYCLES, 1, number of cycles rd_en/wr_en stay asserted per access (legal range 1-15).
- ADDR_W, 16, requester address width; bit ADDR_W-1 is the region select (0 = ROM, 1 = RAM).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- p0_req  in  1  fetch read request; held high until p0_ack.
- p0_addr  in  16  fetch address.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  8  read data; valid with p0_ack and held until the next p0 completion.
- p1_req  in  1  data request; held until p1_ack.
- p1_we  in  1  1 = write, 0 = read.
- p1_addr  in  16  data address.
- p1_wdata  in  8  write data.
- p1_ack  out  1  one-cycle completion pulse.
- p1_rdata  out  8  read data; valid with p1_ack.
- p1_err  out  1  pulses with p1_ack when a write targeted ROM and was dropped.
- mem_wr_en  out  1  memory write enable.
- mem_rd_en  out  1  memory read enable.
- mem_rom_ram  out  1  0 = ROM selected, 1 = RAM selected.
- mem_addr  out  15  memory address (requester address bits 14:0).
- mem_data  inout  8  shared data bus; driven only during write ACCESS cycles, otherwise Z.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values, applied at any time including mid-access:
  - state = IDLE; all acks and err = 0; mem_wr_en = mem_rd_en = 0.
  - mem_rom_ram = 0; mem_addr = 0; mem_data = Z; rdata regs = 0.
  - Round-robin pointer gives port 0 priority.
  - An in-flight access is abandoned with no ack.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
  - IDLE: samples p0_req and p1_req.
    - One request: grant it.
    - Both: grant the port not served last (pointer); the pointer updates on grant.
    - Latch addr, we (port 0 forces we = 0) and wdata; go to SETUP.
  - SETUP (1 cycle): drive mem_addr = addr[14:0] and mem_rom_ram = addr[15]; enables low.
  - ACCESS (WAIT_CYCLES cycles, counted by a 4-bit counter):
    - Address and region stay stable.
    - Read: mem_rd_en = 1; mem_data sampled into the granted port's rdata on the last ACCESS cycle.
    - Write to RAM: mem_wr_en = 1 and mem_data driven with wdata throughout.
    - Write to ROM: both enables stay 0, the bus stays Z, and the err flag is set.
  - DONE (1 cycle): the granted port's ack = 1 (and p1_err if flagged). Enables drop; bus released. Go to IDLE.
- Latency: a request seen in IDLE at cycle N acks at cycle N+2+WAIT_CYCLES. The next grant is at the earliest in IDLE at N+3+WAIT_CYCLES.
- mem_rd_en and mem_wr_en are never both high. The bus is never driven while mem_rd_en = 1.
- A requester still holding req in the IDLE cycle after its ack is treated as a new request.
- req deassertion before ack is illegal. The controller ignores it and completes the access.
- Requester address, we and wdata changing after grant have no effect, because they are latched.

Optional Feature:
- Macro: MEM_BUS_CTRL_ROM_WRITE_EN.
- Defined (simulation image preload): writes to the ROM region proceed like RAM writes, with mem_wr_en = 1, mem_rom_ram = 0 and the bus driven; p1_err never asserts.
- Undefined (default, synthesis): ROM writes are dropped and flagged as described in Behaviour.

Decomposition:
- Shared package mem_bus_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE).
  - REGION_ROM = 1'b0 and REGION_RAM = 1'b1.
  - MEM_ADDR_W = 15 and MEM_DATA_W = 8.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with grant and pointer update.

Test Plan:
- Reset, then p0_req read of 0x0010 with ROM[0x0010] = 8'hA5 and WAIT_CYCLES = 1 -> rd_en high for 1 cycle with rom_ram = 0; p0_ack 3 cycles after the sample; p0_rdata = 8'hA5.
- p1 write of 8'h3C to 0x8005, then p1 read of 0x8005 -> wr_en with rom_ram = 1, addr 0x0005, bus = 8'h3C; read returns 8'h3C; p1_err = 0.
- p1 write to 0x0005 with the macro undefined -> no wr_en, bus Z, p1_ack and p1_err pulse together; the ROM word is unchanged.
- Same write with MEM_BUS_CTRL_ROM_WRITE_EN defined -> wr_en asserted with rom_ram = 0; a readback returns the written value; err stays 0.
- p0 and p1 both requesting continuously for 4 transactions -> grants alternate p0, p1, p0, p1; the two enables never overlap.
- rst_n low during ACCESS of a RAM write with WAIT_CYCLES = 4 -> the next cycle has enables 0, bus Z, no ack, state IDLE; the first post-reset contention grants p0.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the ROM/RAM bus controller.
package mem_bus_pkg;

    localparam int unsigned MEM_ADDR_W = 15;
    localparam int unsigned MEM_DATA_W = 8;

    localparam logic REGION_ROM = 1'b0;
    localparam logic REGION_RAM = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the granted port when update_i is high.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // prio_q = 0 favours port 0 on contention, 1 favours port 1
    logic prio_q, prio_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (update_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-requester ROM/RAM bus sequencer: IDLE -> SETUP -> ACCESS -> DONE.
// Define MEM_BUS_CTRL_ROM_WRITE_EN to let writes into the ROM region reach the bus.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic [ADDR_W-1:0]     p0_addr,
    output logic                  p0_ack,
    output logic [MEM_DATA_W-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [MEM_DATA_W-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [MEM_DATA_W-1:0] p1_rdata,
    output logic                  p1_err,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic                  mem_rom_ram,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    inout  wire  [MEM_DATA_W-1:0] mem_data
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  port_q, port_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [MEM_DATA_W-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [MEM_DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [MEM_DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic [1:0] gnt;
    logic       rom_wr_blocked;
    logic       in_access;

    rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    ({p1_req, p0_req}),
        .update_i (state_q == StIdle),
        .gnt_o    (gnt)
    );

`ifdef MEM_BUS_CTRL_ROM_WRITE_EN
    assign rom_wr_blocked = 1'b0;
`else
    assign rom_wr_blocked = we_q && (addr_q[ADDR_W-1] == REGION_ROM);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            StIdle: begin
                if (gnt != 2'b00) begin
                    port_d  = gnt[1];
                    addr_d  = gnt[1] ? p1_addr : p0_addr;
                    we_d    = gnt[1] & p1_we;
                    wdata_d = p1_wdata;
                    err_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = 4'd0;
                err_d   = rom_wr_blocked;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (port_q) begin
                            p1_rdata_d = mem_data;
                        end else begin
                            p0_rdata_d = mem_data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            port_q     <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Address/region come straight from the latched request so they are stable from SETUP on
    assign in_access   = (state_q == StAccess);
    assign mem_rd_en   = in_access & ~we_q;
    assign mem_wr_en   = in_access & we_q & ~rom_wr_blocked;
    assign mem_data    = mem_wr_en ? wdata_q : {MEM_DATA_W{1'bz}};
    assign mem_addr    = addr_q[MEM_ADDR_W-1:0];
    assign mem_rom_ram = addr_q[ADDR_W-1];

    assign p0_ack   = (state_q == StDone) & ~port_q;
    assign p1_ack   = (state_q == StDone) & port_q;
    assign p1_err   = p1_ack & err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule
